// File: rtl/mdu_iter_if.sv
// Request/response bundle between the control unit and the iterative
// multiply/divide unit: start/op/operands/flush in, busy/done/HI/LO out.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU use one shift-add step per cycle, DIV/DIVU one restoring
// shift-subtract step per cycle, both on operand magnitudes; signs are
// restored in the FIN cycle. MTHI/MTLO write HI/LO directly from IDLE.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic             accept_md;   // mult/div accepted on this edge
    logic             accept_mt;   // MTHI/MTLO accepted on this edge
    logic             finish;      // FIN cycle that commits a result

    // Operation context captured at the accepting edge
    logic             is_div_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] raw_a_q;
    logic [WIDTH-1:0] mcand_q;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] work_hi_q;   // partial product high half / remainder
    logic [WIDTH-1:0] work_lo_q;   // multiplier / dividend shifting into quotient
    logic [CW-1:0]    count_q;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    // Operand decode for the accepting edge
    logic             is_md_op;
    logic             is_mt_op;
    logic             op_signed;
    logic             src_a_neg;
    logic             src_b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign is_md_op  = (bus.op[2] == 1'b0);
    assign is_mt_op  = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
    assign op_signed = ~bus.op[0];
    assign src_a_neg = op_signed & bus.src_a[WIDTH-1];
    assign src_b_neg = op_signed & bus.src_b[WIDTH-1];
    assign mag_a     = src_a_neg ? -bus.src_a : bus.src_a;
    assign mag_b     = src_b_neg ? -bus.src_b : bus.src_b;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case statement can infer a latch.
        state_d   = state_q;
        accept_md = 1'b0;
        accept_mt = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (is_md_op) begin
                        accept_md = 1'b1;
                        state_d   = CALC;
                    end else if (is_mt_op) begin
                        accept_mt = 1'b1;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                finish  = !bus.flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        add_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mcand_q} : '0);
        rem_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mcand_q};
        if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
                step_hi = rem_diff[WIDTH-1:0];
                step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_shift[WIDTH-1:0];
                step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], work_lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in FIN
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod_mag = {work_hi_q, work_lo_q};
        prod_res = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
        if (!is_div_q) begin
            res_hi = prod_res[2*WIDTH-1:WIDTH];
            res_lo = prod_res[WIDTH-1:0];
        end else if (div_zero_q) begin
            res_hi = raw_a_q;
            res_lo = '1;
        end else begin
            res_hi = neg_a_q ? -work_hi_q : work_hi_q;
            res_lo = (neg_a_q ^ neg_b_q) ? -work_lo_q : work_lo_q;
        end
    end

    // Working registers: loaded at accept, stepped while in CALC
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; these are always loaded at the
        // accepting edge before any cycle reads them.
        if (accept_md) begin
            is_div_q   <= bus.op[1];
            neg_a_q    <= src_a_neg;
            neg_b_q    <= src_b_neg;
            div_zero_q <= (bus.src_b == '0);
            raw_a_q    <= bus.src_a;
            mcand_q    <= mag_b;
            work_hi_q  <= '0;
            work_lo_q  <= mag_a;
            count_q    <= '0;
        end else if (state_q == CALC) begin
            work_hi_q  <= step_hi;
            work_lo_q  <= step_lo;
            count_q    <= count_q + CW'(1);
        end
    end

    // Architectural HI/LO and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (accept_mt) begin
                if (bus.op == OP_MTHI) begin
                    hi_q <= bus.src_a;
                end else begin
                    lo_q <= bus.src_a;
                end
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a 32-bit and an 8-bit instance, each
// compared against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mdu_iter_if #(.WIDTH(32)) bus32 ();
    mdu_iter_if #(.WIDTH(8))  bus8 ();

    mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: {hi, lo} from plain integer arithmetic at width w
    function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub, sa, sb, p, rh, rl;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        rh   = 0;
        rl   = 0;
        case (op)
            3'd0: begin p = sa * sb; rh = (p >> w) & mask; rl = p & mask; end
            3'd1: begin p = ua * ub; rh = (p >> w) & mask; rl = p & mask; end
            3'd2: begin
                if (ub == 0) begin rh = ua; rl = mask; end
                else begin rh = (sa % sb) & mask; rl = (sa / sb) & mask; end
            end
            3'd3: begin
                if (ub == 0) begin rh = ua; rl = mask; end
                else begin rh = ua % ub; rl = ua / ub; end
            end
            default: ;
        endcase
        return {rh[31:0], rl[31:0]};
    endfunction

    // Issue one op on the 32-bit unit and measure busy length, done pulses,
    // HI/LO movement before completion, and the final HI/LO.
    task automatic exec32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int ndone, output bit early,
                          output logic [31:0] rhi, output logic [31:0] rlo);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = bus32.hi;
        l0 = bus32.lo;
        bus32.start = 1'b1; bus32.op = op; bus32.src_a = a; bus32.src_b = b;
        @(negedge clk);
        bus32.start = 1'b0; bus32.src_a = $urandom; bus32.src_b = $urandom;
        lat = 0; ndone = 0; early = 1'b0;
        while (bus32.busy && lat < 200) begin
            lat++;
            if (bus32.done) ndone++;
            if (bus32.hi !== h0 || bus32.lo !== l0) early = 1'b1;
            @(negedge clk);
        end
        if (bus32.done) ndone++;
        rhi = bus32.hi;
        rlo = bus32.lo;
        @(negedge clk);
        if (bus32.done) ndone++;
    endtask

    task automatic exec8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int ndone,
                         output logic [7:0] rhi, output logic [7:0] rlo);
        bus8.start = 1'b1; bus8.op = op; bus8.src_a = a; bus8.src_b = b;
        @(negedge clk);
        bus8.start = 1'b0; bus8.src_a = 8'($urandom); bus8.src_b = 8'($urandom);
        lat = 0; ndone = 0;
        while (bus8.busy && lat < 100) begin
            lat++;
            if (bus8.done) ndone++;
            @(negedge clk);
        end
        if (bus8.done) ndone++;
        rhi = bus8.hi;
        rlo = bus8.lo;
        @(negedge clk);
        if (bus8.done) ndone++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus32.busy); end
        total++; if (bus32.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus32.done); end
        total++; if (bus32.hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus32.hi); end
        total++; if (bus32.lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus32.lo); end
        total++; if ({bus8.busy, bus8.hi, bus8.lo} !== 17'h0) begin bad++; $display("FAIL reset_w8: got %h want 0", {bus8.busy, bus8.hi, bus8.lo}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int lat, nd; bit early; logic [31:0] h, l;
        exec32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nd, early, h, l);
        total++; if (lat !== 33) begin bad++; $display("FAIL multu_latency: got %0d want 33", lat); end
        total++; if (nd !== 1) begin bad++; $display("FAIL multu_done_count: got %0d want 1", nd); end
        total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", h); end
        total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", l); end
    endtask

    task automatic test_mult_signed();
        int lat, nd; bit early; logic [31:0] h, l;
        exec32(3'b000, 32'hFFFF_FFF9, 32'h0000_0003, lat, nd, early, h, l);
        total++; if (early !== 1'b0) begin bad++; $display("FAIL mult_early_update: got %b want 0", early); end
        total++; if (nd !== 1) begin bad++; $display("FAIL mult_done_count: got %0d want 1", nd); end
        total++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_neg: got %h want ffffffffffffffeb", {h, l}); end
    endtask

    task automatic test_div();
        int lat, nd; bit early; logic [31:0] h, l;
        exec32(3'b010, 32'hFFFF_FFF9, 32'h2, lat, nd, early, h, l);
        total++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg7_by_2: got %h want ffffffff_fffffffd", {h, l}); end
        exec32(3'b011, 32'd100, 32'd7, lat, nd, early, h, l);
        total++; if ({h, l} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_by_7: got %h want %h", {h, l}, {32'd2, 32'd14}); end
        exec32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, nd, early, h, l);
        total++; if ({h, l} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_overflow: got %h want 00000000_80000000", {h, l}); end
        total++; if (lat !== 33) begin bad++; $display("FAIL div_latency: got %0d want 33", lat); end
    endtask

    task automatic test_div_zero_ignore_start();
        int lat, nd;
        bus32.start = 1'b1; bus32.op = 3'b011; bus32.src_a = 32'h1234; bus32.src_b = 32'h0;
        @(negedge clk);
        bus32.start = 1'b0;
        lat = 0; nd = 0;
        while (bus32.busy && lat < 200) begin
            lat++;
            if (bus32.done) nd++;
            if (lat == 5) begin
                bus32.start = 1'b1; bus32.op = 3'b001; bus32.src_a = 32'd3; bus32.src_b = 32'd3;
            end else begin
                bus32.start = 1'b0;
            end
            @(negedge clk);
        end
        bus32.start = 1'b0;
        if (bus32.done) nd++;
        total++; if (lat !== 33) begin bad++; $display("FAIL divzero_latency: got %0d want 33", lat); end
        total++; if (bus32.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divzero_lo: got %h want ffffffff", bus32.lo); end
        total++; if (bus32.hi !== 32'h0000_1234) begin bad++; $display("FAIL divzero_hi: got %h want 00001234", bus32.hi); end
        repeat (40) begin
            @(negedge clk);
            if (bus32.done) nd++;
        end
        total++; if (nd !== 1) begin bad++; $display("FAIL busy_start_ignored: got %0d done pulses want 1", nd); end
        total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL busy_start_ignored_busy: got %b want 0", bus32.busy); end
    endtask

    task automatic test_move_and_flush();
        int nd;
        bus32.start = 1'b1; bus32.op = 3'b100; bus32.src_a = 32'hA5A5_A5A5;
        @(negedge clk);
        total++; if (bus32.hi !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mthi: got %h want a5a5a5a5", bus32.hi); end
        total++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin bad++; $display("FAIL mthi_handshake: got busy=%b done=%b want 0 0", bus32.busy, bus32.done); end
        bus32.op = 3'b101; bus32.src_a = 32'h5A5A_5A5A;
        @(negedge clk);
        bus32.start = 1'b0;
        total++; if ({bus32.hi, bus32.lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin bad++; $display("FAIL mtlo: got %h want a5a5a5a5_5a5a5a5a", {bus32.hi, bus32.lo}); end
        total++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin bad++; $display("FAIL mtlo_handshake: got busy=%b done=%b want 0 0", bus32.busy, bus32.done); end
        // unused op code and flush-in-IDLE must both leave HI/LO alone
        bus32.start = 1'b1; bus32.op = 3'b110; bus32.src_a = 32'h1;
        @(negedge clk);
        bus32.op = 3'b100; bus32.flush = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0; bus32.flush = 1'b0;
        total++; if ({bus32.busy, bus32.hi, bus32.lo} !== {1'b0, 64'hA5A5_A5A5_5A5A_5A5A}) begin bad++; $display("FAIL idle_ignored_ops: got %h want 0_a5a5a5a5_5a5a5a5a", {bus32.busy, bus32.hi, bus32.lo}); end
        // MULT 6x7 flushed in its 10th busy cycle
        bus32.start = 1'b1; bus32.op = 3'b000; bus32.src_a = 32'd6; bus32.src_b = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (bus32.busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", bus32.busy); end
        bus32.flush = 1'b1;
        @(negedge clk);
        bus32.flush = 1'b0;
        total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", bus32.busy); end
        nd = 0;
        repeat (40) begin
            if (bus32.done) nd++;
            @(negedge clk);
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL flush_done: got %0d done pulses want 0", nd); end
        total++; if ({bus32.hi, bus32.lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin bad++; $display("FAIL flush_hilo: got %h want a5a5a5a5_5a5a5a5a", {bus32.hi, bus32.lo}); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] exp;
        bus32.start = 1'b1; bus32.op = 3'b001; bus32.src_a = 32'd1000; bus32.src_b = 32'd1000;
        @(negedge clk);
        bus32.start = 1'b0;
        n = 0;
        while (!bus32.done && n < 200) begin n++; @(negedge clk); end
        total++; if (bus32.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", bus32.done); end
        total++; if ({bus32.hi, bus32.lo} !== 64'd1000000) begin bad++; $display("FAIL b2b_first_result: got %h want %h", {bus32.hi, bus32.lo}, 64'd1000000); end
        // new request issued in the done cycle
        bus32.start = 1'b1; bus32.op = 3'b010; bus32.src_a = 32'd100; bus32.src_b = 32'hFFFF_FFF9;
        @(negedge clk);
        bus32.start = 1'b0;
        total++; if ({bus32.busy, bus32.done} !== 2'b10) begin bad++; $display("FAIL b2b_accept: got busy,done=%b want 10", {bus32.busy, bus32.done}); end
        n = 0;
        while (bus32.busy && n < 200) begin n++; @(negedge clk); end
        exp = model(32, 3'b010, 32'd100, 32'hFFFF_FFF9);
        total++; if ({bus32.hi, bus32.lo} !== exp) begin bad++; $display("FAIL b2b_second_result: got %h want %h", {bus32.hi, bus32.lo}, exp); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, nd; bit early; logic [31:0] h, l;
        logic [2:0] op; logic [31:0] a, b; logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20)) ^ {32{b[31]}};
                default: ;
            endcase
            exp = model(32, op, a, b);
            exec32(op, a, b, lat, nd, early, h, l);
            total++; if ({h, l} !== exp || lat !== 33 || nd !== 1 || early !== 1'b0) begin
                bad++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d done=%0d early=%b want %h lat=33 done=1 early=0",
                         i, op, a, b, {h, l}, lat, nd, early, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bus32.start = 1'b1; bus32.op = 3'b010; bus32.src_a = 32'h100; bus32.src_b = 32'd3;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; bus32.start = 1'b1; bus32.op = 3'b011;
        @(negedge clk);
        total++; if ({bus32.busy, bus32.done} !== 2'b00) begin bad++; $display("FAIL rst_mid_handshake: got busy,done=%b want 00", {bus32.busy, bus32.done}); end
        total++; if ({bus32.hi, bus32.lo} !== 64'h0) begin bad++; $display("FAIL rst_mid_hilo: got %h want 0", {bus32.hi, bus32.lo}); end
        rst = 1'b0; bus32.start = 1'b0;
        @(negedge clk);
        total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL rst_start_dropped: got %b want 0", bus32.busy); end
    endtask

    task automatic test_width8();
        int lat, nd; logic [7:0] h, l; logic [2:0] op; logic [7:0] a, b; logic [63:0] exp;
        exec8(3'b001, 8'hFF, 8'hFF, lat, nd, h, l);
        total++; if (lat !== 9) begin bad++; $display("FAIL w8_latency: got %0d want 9", lat); end
        total++; if (nd !== 1) begin bad++; $display("FAIL w8_done_count: got %0d want 1", nd); end
        total++; if ({h, l} !== 16'hFE01) begin bad++; $display("FAIL w8_multu: got %h want fe01", {h, l}); end
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom);
            exp = model(8, op, {24'h0, a}, {24'h0, b});
            exec8(op, a, b, lat, nd, h, l);
            total++; if ({h, l} !== exp[39:32] * 0 + {exp[39:32], exp[7:0]} || lat !== 9 || nd !== 1) begin
                bad++;
                $display("FAIL w8_random_%0d op=%0d a=%h b=%h: got %h lat=%0d done=%0d want %h lat=9 done=1",
                         i, op, a, b, {h, l}, lat, nd, {exp[39:32], exp[7:0]});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus32.start = 1'b0; bus32.op = 3'b0; bus32.src_a = '0; bus32.src_b = '0; bus32.flush = 1'b0;
        bus8.start  = 1'b0; bus8.op  = 3'b0; bus8.src_a  = '0; bus8.src_b  = '0; bus8.flush  = 1'b0;
        @(negedge clk);
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div();
        test_div_zero_ignore_start();
        test_move_and_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, the multi-cycle arithmetic block the CPU needs next for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits beside the ALU and takes the register-file read operands.
- Uses a start/busy/done handshake, so the control unit stalls the PC while the unit is busy.
- Word width is generic. Operations can be aborted by a flush.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (≥4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request pulse; accepted only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
src_b  input  WIDTH  multiplier / divisor
flush  input  1  abort in-flight operation
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Interface decision: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge): state returns to IDLE; busy=0, done=0, hi=0, lo=0. Reset dominates start and flush. Reset mid-operation discards the operation.
- FSM states: IDLE, CALC, FIN.
  - IDLE→CALC: start=1 with op ∈ {000..011}. The edge latches operands, op, and iteration counter=0.
  - IDLE stays IDLE on start with MTHI/MTLO. On that edge hi<=src_a (MTHI) or lo<=src_a (MTLO). busy and done stay 0.
  - Unused op codes are ignored.
  - CALC: one shift-add (mult) or one restoring shift-subtract (div) step per cycle on magnitudes. Counter increments. After the WIDTH-th step, go to FIN.
  - FIN: apply sign correction and write hi/lo. Go to IDLE. done=1 during the cycle after this edge.
- Timing: busy=1 from the cycle after the accepting edge through the FIN cycle, i.e. WIDTH+1 cycles. hi/lo change exactly once, at the FIN→IDLE edge.
  - done is high for exactly one cycle, and busy is 0 in that cycle.
  - A new start may be accepted in the done cycle.
- start while busy=1 is ignored. No queueing.
- flush=1 while busy: next edge goes to IDLE, busy=0, done stays 0, hi/lo unchanged. flush in IDLE has no effect, and a same-cycle start is also dropped.
- MULT/MULTU: 2·WIDTH-bit product; hi=upper WIDTH bits, lo=lower WIDTH bits. MULT is two's-complement signed, MULTU is unsigned.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow (most-negative ÷ −1): lo=most-negative, hi=0.
- Divide by zero: still takes full latency. lo=all ones, hi=src_a (raw dividend), for both DIV and DIVU.
- Operands are sampled only at the accepting edge. src_a/src_b changes during busy have no effect.
- hi/lo are registered outputs, never combinational from inputs.

Test Plan:
1. Reset, then MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF → busy for 33 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT src_a=0xFFFFFFF9 (−7), src_b=0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21); done exactly 1 cycle; hi/lo unchanged before FIN.
3. DIV −7/2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x00001234 after full latency. Second start issued while busy is ignored: a single done, result from the first op.
5. MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive cycles → hi/lo update next edge, busy never rises, no done. Then MULT 6×7, flush at 10th busy cycle → busy drops next edge, no done, hi/lo keep 0xA5A5A5A5/0x5A5A5A5A.
6. rst asserted mid-DIV together with start → next edge: busy=0, done=0, hi=lo=0. WIDTH=8 build: MULTU 0xFF×0xFF → busy 9 cycles, hi=0xFE, lo=0x01.
